// File: rtl/fft_pkg.sv
// Shared constants and types for the 1024-point SDF FFT pipeline.
//   DATA_W : signed width of samples and twiddle words
//   FRAC_W : fractional bits of twiddle (1 << FRAC_W == +1.0)
//   phase_e: phase codes presented by the twiddle ROM
//   cplx_t : complex sample (re/im, signed DATA_W)
package fft_pkg;
  localparam int DATA_W = 24;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2
  } phase_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/sdf_delay_line.sv
// DEPTH-entry complex circular buffer used as the SDF feedback delay.
//   clk, rst_n : clock, async active-low reset (clears pointer and entries)
//   push_i     : write wdata_i at the pointer slot, then advance the pointer
//   wdata_i    : complex sample to store
//   head_o     : entry at the pointer (oldest sample, DEPTH pushes ago)
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  cplx_t wdata_i,
  output cplx_t head_o
);
  localparam int PW = $clog2(DEPTH);

  cplx_t          mem_q [DEPTH];
  logic [PW-1:0]  ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= wdata_i;
      ptr_q        <= (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + PW'(1);
    end
  end

  assign head_o = mem_q[ptr_q];
endmodule

// File: rtl/fft_sdf_r2_stage16.sv
// Radix-2 SDF butterfly stage, delay 16, for the 1024-point FFT.
// Sample/twiddle widths come from fft_pkg (DATA_W, FRAC_W).
//   clk, rst_n       : clock, async active-low reset
//   in_valid         : din_r/din_i carry a sample
//   din_r, din_i     : input sample
//   state            : 0 fill, 1 butterfly, 2 twiddle-multiply, 3 as fill
//   w_r, w_i         : twiddle, signed Q.FRAC_W, aligned with the head entry
//   out_valid        : dout_r/dout_i valid (registered, 1-cycle latency)
//   dout_r, dout_i   : output sample
// Build option: FFT_SDF_ROUND_EN adds round-half-up before the twiddle
// product shift; otherwise the shift floors.
module fft_sdf_r2_stage16
  import fft_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic [1:0]               state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);
  localparam int MW = 2*DATA_W+1;

  phase_e ph;
  cplx_t  head, bin, push_d, dout_d, dout_q;
  logic   push, vld_d, vld_q;

  // Code 3 is not a real phase; it behaves as fill.
  always_comb begin
    case (state)
      2'd1:    ph = ST_BFLY;
      2'd2:    ph = ST_TWID;
      default: ph = ST_FILL;
    endcase
  end

  // A missing sample contributes zero in butterfly/twiddle phases.
  assign bin.re = in_valid ? din_r : '0;
  assign bin.im = in_valid ? din_i : '0;

  // Full-precision complex product, optional rounding, then shift.
  logic signed [MW-1:0] hr, hi, wr_x, wi_x, pr, pi;
  assign hr   = MW'(head.re);
  assign hi   = MW'(head.im);
  assign wr_x = MW'(w_r);
  assign wi_x = MW'(w_i);
`ifdef FFT_SDF_ROUND_EN
  localparam logic signed [MW-1:0] RND = MW'(1) <<< (FRAC_W-1);
  assign pr = hr*wr_x - hi*wi_x + RND;
  assign pi = hr*wi_x + hi*wr_x + RND;
`else
  assign pr = hr*wr_x - hi*wi_x;
  assign pi = hr*wi_x + hi*wr_x;
`endif

  always_comb begin
    push   = 1'b0;
    push_d = '{re: din_r, im: din_i};
    dout_d = '0;
    vld_d  = 1'b0;
    case (ph)
      ST_FILL: push = in_valid;
      ST_BFLY: begin
        // Sum/difference wrap to DATA_W; headroom is provided upstream.
        push      = 1'b1;
        vld_d     = 1'b1;
        dout_d.re = DATA_W'((DATA_W+1)'(head.re) + (DATA_W+1)'(bin.re));
        dout_d.im = DATA_W'((DATA_W+1)'(head.im) + (DATA_W+1)'(bin.im));
        push_d.re = DATA_W'((DATA_W+1)'(head.re) - (DATA_W+1)'(bin.re));
        push_d.im = DATA_W'((DATA_W+1)'(head.im) - (DATA_W+1)'(bin.im));
      end
      ST_TWID: begin
        push      = 1'b1;
        vld_d     = 1'b1;
        push_d    = bin;
        dout_d.re = DATA_W'(pr >>> FRAC_W);
        dout_d.im = DATA_W'(pi >>> FRAC_W);
      end
      default: ;
    endcase
  end

  sdf_delay_line #(.DEPTH(DEPTH)) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_d),
    .head_o  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  assign out_valid = vld_q;
  assign dout_r    = dout_q.re;
  assign dout_i    = dout_q.im;
endmodule

// File: tb/tb_fft_sdf_r2_stage16.sv
// Self-checking bench for fft_sdf_r2_stage16: a FIFO reference model of the
// feedback delay produces expected outputs, queued at drive time and popped
// when the DUT presents them one cycle later.
module tb_fft_sdf_r2_stage16;
  localparam int W = 24;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic signed [W-1:0] din_r, din_i, w_r, w_i;
  logic [1:0]          state;
  logic                out_valid;
  logic signed [W-1:0] dout_r, dout_i;

  fft_sdf_r2_stage16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference delay: head is the oldest of 16 entries.
  longint mq_r[$], mq_i[$];
  longint eq_r[$], eq_i[$];

  function automatic longint wrap(input longint v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return longint'($signed(t));
  endfunction

  task automatic model_reset();
    mq_r.delete(); mq_i.delete(); eq_r.delete(); eq_i.delete();
    for (int i = 0; i < 16; i++) begin
      mq_r.push_back(0); mq_i.push_back(0);
    end
  endtask

  task automatic mpush(input longint r, input longint i);
    void'(mq_r.pop_front()); void'(mq_i.pop_front());
    mq_r.push_back(wrap(r)); mq_i.push_back(wrap(i));
  endtask

  // Drive one cycle (called #1 after a rising edge) and check its result.
  task automatic step(input int st, input bit vld, input int dr, input int di,
                      input int wr = 0, input int wi = 0);
    longint hr, hi, br, bi, pr, pi;
    int stq;
    bit exp_v;
    state = 2'(st); in_valid = vld; din_r = W'(dr); din_i = W'(di);
    w_r = W'(wr); w_i = W'(wi);
    stq = (st == 3) ? 0 : st;
    hr = mq_r[0]; hi = mq_i[0];
    br = vld ? longint'(dr) : 0;
    bi = vld ? longint'(di) : 0;
    exp_v = (stq != 0);
    if (stq == 0) begin
      if (vld) mpush(dr, di);
    end else if (stq == 1) begin
      eq_r.push_back(wrap(hr + br)); eq_i.push_back(wrap(hi + bi));
      mpush(hr - br, hi - bi);
    end else begin
      pr = hr*wr - hi*wi;
      pi = hr*wi + hi*wr;
`ifdef FFT_SDF_ROUND_EN
      pr += 128; pi += 128;
`endif
      eq_r.push_back(wrap(pr >>> 8)); eq_i.push_back(wrap(pi >>> 8));
      mpush(br, bi);
    end
    @(posedge clk); #1;
    chk("out_valid", longint'(out_valid), longint'(exp_v));
    if (exp_v) begin
      chk("dout_r", dout_r, eq_r.pop_front());
      chk("dout_i", dout_i, eq_i.pop_front());
    end
  endtask

  initial begin
    // Reset held while inputs look like an active butterfly.
    rst_n = 1'b0; state = 2'd1; in_valid = 1'b1; din_r = 5; din_i = 5;
    w_r = 0; w_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovld", out_valid, 0);
    chk("rst_dr", dout_r, 0);
    chk("rst_di", dout_i, 0);
    model_reset();
    state = 2'd0; in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with a 4-cycle gap; last push uses phase code 3.
    for (int k = 0; k < 16; k++) begin
      step((k == 15) ? 3 : 0, 1, k, 0);
      if (k == 7) for (int g = 0; g < 4; g++) step(0, 0, 999, 7);
    end
    // Butterfly: k + 100.
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 100, 0);
      chk("bfly_const", dout_r, k + 100);
    end
    // Twiddle: unit, with -j at k=8 (head -92); pushes next frame k+1.
    for (int k = 0; k < 16; k++) begin
      if (k == 8) step(2, 1, k + 1, 0, 0, -256);
      else        step(2, 1, k + 1, 0, 256, 0);
      if (k == 3) chk("twid_k3", dout_r, -97);
      if (k == 8) begin
        chk("negj_r", dout_r, 0);
        chk("negj_i", dout_i, 92);
      end
    end
    // Butterfly leaving (3,0) in every slot.
    for (int k = 0; k < 16; k++) step(1, 1, k - 2, 0);
    // Rounding twiddle on head (3,0).
    for (int k = 0; k < 16; k++) begin
      step(2, 0, 0, 0, 181, -181);
      if (k == 0) begin
        chk("rnd_r", dout_r, 2);
`ifdef FFT_SDF_ROUND_EN
        chk("rnd_i", dout_i, -2);
`else
        chk("rnd_i", dout_i, -3);
`endif
      end
    end

    // New frame, reset pulsed in the 5th butterfly cycle.
    for (int k = 0; k < 16; k++) step(0, 1, k*7, -k);
    for (int k = 0; k < 4; k++) step(1, 1, k, k);
    state = 2'd1; in_valid = 1'b1; din_r = 50; din_i = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ovld", out_valid, 0);
    chk("mrst_dr", dout_r, 0);
    chk("mrst_di", dout_i, 0);
    model_reset();
    state = 2'd0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ovld", out_valid, 0);
    for (int k = 0; k < 16; k++) step(0, 1, 1000 + k, 3);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 1, -3);
      chk("post_rst_bfly", dout_r, 1001 + k);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
